// File: rtl/instr_fetch.sv
// Instruction fetch unit: one bus word read per accepted fetch request.
// Handles waitrequest stalls, optional byte reordering, misaligned-PC and stall-timeout faults.
module instr_fetch #(
   parameter int BYTE_SWAP = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        fetch_i,
   input  logic [31:0] pc_i,
   output logic [31:0] mem_address_o,
   output logic        mem_read_o,
   output logic [3:0]  mem_byteenable_o,
   input  logic        mem_waitrequest_i,
   input  logic [31:0] mem_readdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        busy_o,
   output logic        fault_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic        r_read;
   logic [31:0] r_instr;
   logic        r_valid;
   logic        r_fault;
   logic [15:0] r_wait_cnt;
   logic [31:0] w_rdata;

   generate
      if (BYTE_SWAP != 0) begin : g_swap
         assign w_rdata = {mem_readdata_i[7:0], mem_readdata_i[15:8],
                           mem_readdata_i[23:16], mem_readdata_i[31:24]};
      end else begin : g_noswap
         assign w_rdata = mem_readdata_i;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_read     <= 1'b0;
         r_instr    <= '0;
         r_valid    <= 1'b0;
         r_fault    <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fetch_i && !r_fault) begin
                  if (pc_i[1:0] == 2'b00) begin
                     r_addr     <= pc_i;
                     r_wait_cnt <= '0;
                     r_read     <= 1'b1;
                     r_state    <= S_REQ;
                  end else begin
                     r_fault <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (!mem_waitrequest_i) begin
                  r_read  <= 1'b0;
                  r_state <= S_RESP;
               end else if (r_wait_cnt == 16'(TIMEOUT)) begin
                  // TIMEOUT stall cycles already tolerated; abandon the read
                  r_fault <= 1'b1;
                  r_read  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_RESP: begin
               r_instr <= w_rdata;
               r_valid <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_address_o    = r_addr;
   assign mem_read_o       = r_read;
   assign mem_byteenable_o = {4{r_read}};
   assign instr_o          = r_instr;
   assign instr_valid_o    = r_valid;
   assign busy_o           = (r_state != S_IDLE);
   assign fault_o          = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: default instance plus a BYTE_SWAP=1, TIMEOUT=3 instance on shared inputs.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset_i, fetch_i, mem_waitrequest_i;
   logic [31:0] pc_i, mem_readdata_i;

   logic [31:0] a_addr, a_instr, b_addr, b_instr;
   logic        a_read, a_valid, a_busy, a_fault;
   logic        b_read, b_valid, b_busy, b_fault;
   logic [3:0]  a_be, b_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch dut_a (
      .clk(clk), .reset_i(reset_i), .fetch_i(fetch_i), .pc_i(pc_i),
      .mem_address_o(a_addr), .mem_read_o(a_read), .mem_byteenable_o(a_be),
      .mem_waitrequest_i(mem_waitrequest_i), .mem_readdata_i(mem_readdata_i),
      .instr_o(a_instr), .instr_valid_o(a_valid), .busy_o(a_busy), .fault_o(a_fault)
   );

   instr_fetch #(.BYTE_SWAP(1), .TIMEOUT(3)) dut_b (
      .clk(clk), .reset_i(reset_i), .fetch_i(fetch_i), .pc_i(pc_i),
      .mem_address_o(b_addr), .mem_read_o(b_read), .mem_byteenable_o(b_be),
      .mem_waitrequest_i(mem_waitrequest_i), .mem_readdata_i(mem_readdata_i),
      .instr_o(b_instr), .instr_valid_o(b_valid), .busy_o(b_busy), .fault_o(b_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one fetch on instance A; nwait cycles of waitrequest, then tracks the handshake.
   task automatic run_a(input logic [31:0] pc, input int nwait,
                        output int rd_cyc, output int vld_cyc, output int addr_bad);
      rd_cyc = 0; vld_cyc = 0; addr_bad = 0;
      pc_i = pc; fetch_i = 1'b1; mem_waitrequest_i = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         fetch_i = 1'b0;
         mem_waitrequest_i = (n <= nwait);
         if (a_read) begin
            rd_cyc++;
            if (a_addr !== pc || a_be !== 4'hF) addr_bad++;
         end
         if (a_valid) begin
            vld_cyc = n;
            break;
         end
      end
      tick();
   endtask

   initial begin
      int rd, vld, bad, vcnt;
      reset_i = 1'b1; fetch_i = 1'b0; pc_i = '0;
      mem_waitrequest_i = 1'b0; mem_readdata_i = '0;
      tick(); tick();
      reset_i = 1'b0;
      chk("rst_read",  {31'd0, a_read},  32'd0);
      chk("rst_addr",  a_addr,           32'd0);
      chk("rst_instr", a_instr,          32'd0);
      chk("rst_flags", {29'd0, a_valid, a_busy, a_fault}, 32'd0);
      chk("rst_be",    {28'd0, a_be},    32'd0);

      // zero-wait fetch
      mem_readdata_i = 32'h24020005;
      run_a(32'hBFC00000, 0, rd, vld, bad);
      chk("zw_read_cycles", rd, 1);
      chk("zw_addr",        bad, 0);
      chk("zw_valid_cycle", vld, 3);
      chk("zw_instr",       a_instr, 32'h24020005);
      chk("zw_valid_pulse", {31'd0, a_valid}, 32'd0);
      chk("zw_busy_after",  {31'd0, a_busy},  32'd0);

      // four wait states
      mem_readdata_i = 32'h8C220010;
      run_a(32'hBFC00010, 4, rd, vld, bad);
      chk("ws_read_cycles", rd, 5);
      chk("ws_addr_stable", bad, 0);
      chk("ws_valid_cycle", vld, 7);
      chk("ws_instr",       a_instr, 32'h8C220010);

      // byte swap on instance B
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      mem_readdata_i = 32'h05000224;
      pc_i = 32'hBFC00000; fetch_i = 1'b1;
      tick(); fetch_i = 1'b0;
      tick(); tick();
      chk("bs_valid", {31'd0, b_valid}, 32'd1);
      chk("bs_instr", b_instr, 32'h24020005);
      chk("bs_noswap_instr", a_instr, 32'h05000224);
      tick();

      // timeout on instance B with waitrequest stuck high
      mem_waitrequest_i = 1'b1;
      pc_i = 32'hBFC00020; fetch_i = 1'b1;
      rd = 0; vcnt = 0;
      for (int n = 1; n <= 8; n++) begin
         tick(); fetch_i = 1'b0;
         if (b_read) rd++;
         if (b_valid) vcnt++;
      end
      chk("to_read_cycles", rd, 4);
      chk("to_fault",       {31'd0, b_fault}, 32'd1);
      chk("to_read_low",    {31'd0, b_read},  32'd0);
      chk("to_no_valid",    vcnt, 0);
      chk("to_instr_held",  b_instr, 32'h24020005);
      chk("to_a_still_req", {31'd0, a_read},  32'd1);

      // misaligned PC on instance A
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      mem_waitrequest_i = 1'b0;
      pc_i = 32'hBFC00002; fetch_i = 1'b1;
      tick(); fetch_i = 1'b0;
      chk("mis_fault", {31'd0, a_fault}, 32'd1);
      chk("mis_read",  {31'd0, a_read},  32'd0);
      pc_i = 32'hBFC00000; fetch_i = 1'b1;
      rd = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (a_read || a_busy) rd++;
      end
      fetch_i = 1'b0;
      chk("mis_ignored", rd, 0);
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      chk("mis_rst_clear", {31'd0, a_fault}, 32'd0);
      mem_readdata_i = 32'h00000013;
      run_a(32'hBFC00000, 0, rd, vld, bad);
      chk("mis_refetch_vld",   vld, 3);
      chk("mis_refetch_instr", a_instr, 32'h00000013);

      // reset during stalled REQ
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      pc_i = 32'hBFC00040; fetch_i = 1'b1; mem_waitrequest_i = 1'b1;
      tick(); fetch_i = 1'b0;
      tick();
      chk("rr_in_req", {31'd0, a_read}, 32'd1);
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      chk("rr_read",  {31'd0, a_read}, 32'd0);
      chk("rr_busy",  {31'd0, a_busy}, 32'd0);
      chk("rr_instr", a_instr, 32'd0);
      mem_waitrequest_i = 1'b0; mem_readdata_i = 32'hFFFFFFFF;
      vcnt = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (a_valid) vcnt++;
      end
      chk("rr_no_valid",     vcnt, 0);
      chk("rr_no_capture",   a_instr, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer side of the instruction path: issues word reads for the current PC on the CPU memory bus and delivers the fetched word to the instruction register.
- The IR consumes this word as its instruction input during EXEC1.
- Owns the bus read handshake: waitrequest stalls, optional byte-lane reordering, misaligned-PC detection and a stall timeout.
- Sits between the control FSM (FETCH request) and the top-level memory port.

Parameters:
- BYTE_SWAP, 0, when 1 instr_o = {rd[7:0], rd[15:8], rd[23:16], rd[31:24]}; when 0 instr_o = readdata unchanged.
- TIMEOUT, 255, maximum consecutive waitrequest-high cycles tolerated in REQ before fault; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- fetch_i  input  1  fetch request from control FSM; sampled only in IDLE.
- pc_i  input  32  address to fetch; latched when a fetch is accepted.
- mem_address_o  output  32  bus address (latched PC).
- mem_read_o  output  1  bus read strobe.
- mem_byteenable_o  output  4  4'b1111 while mem_read_o=1, else 4'b0000.
- mem_waitrequest_i  input  1  bus stall; read accepted in a cycle with mem_read_o=1 and waitrequest=0.
- mem_readdata_i  input  32  read data, valid the cycle after acceptance.
- instr_o  output  32  last fetched instruction; held until next capture.
- instr_valid_o  output  1  one-cycle pulse when instr_o is updated.
- busy_o  output  1  high in any state other than IDLE.
- fault_o  output  1  sticky error flag (misaligned PC or timeout).

Behaviour:
- Reset (reset_i=1 at a posedge, from any state including mid-read):
  - state=IDLE; mem_address_o=0; mem_read_o=0; instr_o=0; instr_valid_o=0; fault_o=0; wait counter=0.
  - An in-flight read is abandoned; a readdata arriving afterwards is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - fetch_i=1, pc_i[1:0]=0 and fault_o=0 -> latch pc_i into mem_address_o, clear wait counter, go to REQ.
  - fetch_i=1 with pc_i[1:0]!=0 -> set fault_o, stay in IDLE, no bus read.
  - fetch_i while fault_o=1 -> ignored.
- REQ:
  - mem_read_o=1, byteenable=1111. The address is stable for the whole of REQ; pc_i and fetch_i are ignored.
  - waitrequest=0 -> go to RESP.
  - waitrequest=1 -> increment counter and stay in REQ. If the counter has reached TIMEOUT -> set fault_o, drop mem_read_o, go to IDLE without capture.
- RESP:
  - mem_read_o=0.
  - Capture mem_readdata_i, with BYTE_SWAP applied, into instr_o.
  - Go to IDLE; instr_valid_o=1 in the following cycle only.
- Latency (zero wait states):
  - fetch_i sampled at edge 0 -> mem_read_o high in cycle 1 -> RESP in cycle 2.
  - instr_o updated and instr_valid_o=1 in cycle 3; each wait cycle adds 1.
- fetch_i high in the cycle instr_valid_o pulses: accepted (state is IDLE), so back-to-back fetches run every 3 cycles.
- fetch_i while busy_o=1: dropped, not queued.
- instr_valid_o is never high for two consecutive cycles.
- instr_o never changes except on a RESP capture or reset.
- fault_o clears only on reset.

Test Plan:
- Reset, then fetch_i=1 with pc_i=32'hBFC00000, waitrequest=0, readdata=32'h24020005:
  - mem_read_o high exactly 1 cycle with address BFC00000.
  - instr_o=24020005 and instr_valid_o pulse in cycle 3; busy_o low afterwards.
- Same fetch with waitrequest held high 4 cycles:
  - mem_read_o high 5 cycles with address stable.
  - instr_valid_o pulse 4 cycles later than the zero-wait case.
- BYTE_SWAP=1, readdata=32'h05000224 -> instr_o=24020005.
- pc_i=32'hBFC00002 with fetch_i=1 -> fault_o=1, mem_read_o never asserted.
  - A subsequent aligned fetch_i is ignored.
  - reset_i clears fault_o and the next aligned fetch completes.
- TIMEOUT=3, waitrequest stuck high -> fault_o=1, mem_read_o drops, no instr_valid_o pulse, instr_o unchanged.
- reset_i asserted during REQ with waitrequest high:
  - next cycle mem_read_o=0, state IDLE, instr_o=0.
  - readdata=32'hFFFFFFFF presented afterwards is not captured.
